instr_fetch_unit: RTL and testbench

- IF stage of the 5-stage MIPS pipeline; sits directly upstream of the IF/ID pipeline register.
- Owns the PC and issues word requests to instruction memory over a req/ready handshake.
- Holds the returned instruction and its PC+1 in a one-entry output buffer until the IF/ID register accepts it.
- Applies branch/jump redirects from EX and discards stale in-flight fetches.

---
 rtl/instr_fetch_unit.sv | 118 +++++++++++
 tb/tb_instr_fetch_unit.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - MIPS IF stage: PC, imem req/ready fetch, one-entry output buffer, redirects.
module instr_fetch_unit #(
  parameter int          WIDTH    = 32,
  parameter int          ADDR_W   = 10,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [WIDTH-1:0]  imem_rdata,
  input  logic              imem_ready,
  output logic [WIDTH-1:0]  instr_out,
  output logic [ADDR_W-1:0] addr_out,
  output logic              valid_out
);

  typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_DRAIN} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] pc, pc_n, pc_inc;
  logic [ADDR_W-1:0] redirect_pc, redirect_pc_n;
  logic [WIDTH-1:0]  instr_n;
  logic [ADDR_W-1:0] addr_n;
  logic              valid_n;
  logic              req_int;
  logic              consume;

  assign consume   = valid_out & ~stall;
  assign pc_inc    = pc + ADDR_W'(1);
  assign imem_addr = pc;
  // The request is masked during reset so memory never sees a half-formed fetch.
  assign imem_req  = reset & req_int;

  always_comb begin
    state_n       = state;
    pc_n          = pc;
    redirect_pc_n = redirect_pc;
    instr_n       = instr_out;
    addr_n        = addr_out;
    valid_n       = valid_out;
    req_int       = 1'b0;

    case (state)
      ST_RUN: begin
        req_int = (~valid_out | consume) & ~branch_taken;
        if (branch_taken) begin
          pc_n    = branch_target;
          valid_n = 1'b0;
        end else if (req_int && imem_ready) begin
          instr_n = imem_rdata;
          addr_n  = pc_inc;
          valid_n = 1'b1;
          pc_n    = pc_inc;
        end else if (req_int) begin
          state_n = ST_WAIT;
          valid_n = 1'b0;
        end else if (consume) begin
          valid_n = 1'b0;
        end
      end

      ST_WAIT: begin
        req_int = 1'b1;
        if (imem_ready && branch_taken) begin
          pc_n    = branch_target;
          state_n = ST_RUN;
        end else if (imem_ready) begin
          instr_n = imem_rdata;
          addr_n  = pc_inc;
          valid_n = 1'b1;
          pc_n    = pc_inc;
          state_n = ST_RUN;
        end else if (branch_taken) begin
          redirect_pc_n = branch_target;
          state_n       = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        // The stale request must complete before the redirect can be issued.
        req_int = 1'b1;
        if (branch_taken) redirect_pc_n = branch_target;
        if (imem_ready) begin
          pc_n    = branch_taken ? branch_target : redirect_pc;
          state_n = ST_RUN;
        end
      end

      default: begin
        state_n = ST_RUN;
        valid_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_RUN;
      pc          <= ADDR_W'(RESET_PC);
      redirect_pc <= '0;
      instr_out   <= '0;
      addr_out    <= '0;
      valid_out   <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      redirect_pc <= redirect_pc_n;
      instr_out   <= instr_n;
      addr_out    <= addr_n;
      valid_out   <= valid_n;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [9:0]  branch_target;
  logic        imem_req;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] instr_out;
  logic [9:0]  addr_out;
  logic        valid_out;
  logic        bad_data;

  logic        w_req;
  logic [9:0]  w_addr;
  logic [31:0] w_rdata;
  logic [31:0] w_instr;
  logic [9:0]  w_addr_out;
  logic        w_valid;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign imem_rdata = bad_data ? 32'hDEAD_BEEF : (32'hA000_0000 | {22'h0, imem_addr});
  assign w_rdata    = 32'hA000_0000 | {22'h0, w_addr};

  instr_fetch_unit #(.WIDTH(32), .ADDR_W(10), .RESET_PC(0)) u_dut (
    .clk(clk), .reset(reset), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .instr_out(instr_out), .addr_out(addr_out), .valid_out(valid_out)
  );

  instr_fetch_unit #(.WIDTH(32), .ADDR_W(10), .RESET_PC(1022)) u_wrap (
    .clk(clk), .reset(reset), .stall(1'b0),
    .branch_taken(1'b0), .branch_target(10'd0),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_rdata(w_rdata), .imem_ready(1'b1),
    .instr_out(w_instr), .addr_out(w_addr_out), .valid_out(w_valid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_buf(input string tag, input logic v, input logic [31:0] ins, input logic [9:0] a);
    check({tag, "_valid"}, {31'h0, valid_out}, {31'h0, v});
    if (v) begin
      check({tag, "_instr"}, instr_out, ins);
      check({tag, "_addr_out"}, {22'h0, addr_out}, {22'h0, a});
    end
  endtask

  task automatic check_req(input string tag, input logic r, input logic [9:0] a);
    check({tag, "_req"}, {31'h0, imem_req}, {31'h0, r});
    check({tag, "_imem_addr"}, {22'h0, imem_addr}, {22'h0, a});
  endtask

  task automatic step;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    imem_ready = 1'b1; bad_data = 1'b0;
    repeat (2) step();
    #1;
    check("rst_valid", {31'h0, valid_out}, 32'h0);
    check("rst_instr", instr_out, 32'h0);
    check("rst_addr_out", {22'h0, addr_out}, 32'h0);
    check_req("rst", 1'b0, 10'd0);
    check("rst_wrap_req", {31'h0, w_req}, 32'h0);
    check("rst_wrap_pc", {22'h0, w_addr}, 32'd1022);

    // Stream: zero-wait memory, one instruction per cycle.
    step(); reset = 1'b1; #1;
    check_req("s0", 1'b1, 10'd0);
    check("s0_valid", {31'h0, valid_out}, 32'h0);
    check("w0_addr", {22'h0, w_addr}, 32'd1022);
    step(); #1;
    check_buf("s1", 1'b1, 32'hA000_0000, 10'd1); check_req("s1", 1'b1, 10'd1);
    check("w1_addr", {22'h0, w_addr}, 32'd1023);
    check("w1_addr_out", {22'h0, w_addr_out}, 32'd1023);
    check("w1_instr", w_instr, 32'hA000_03FE);
    step(); #1;
    check_buf("s2", 1'b1, 32'hA000_0001, 10'd2); check_req("s2", 1'b1, 10'd2);
    check("w2_addr", {22'h0, w_addr}, 32'd0);
    check("w2_addr_out", {22'h0, w_addr_out}, 32'd0);
    check("w2_instr", w_instr, 32'hA000_03FF);
    step(); #1;
    check_buf("s3", 1'b1, 32'hA000_0002, 10'd3); check_req("s3", 1'b1, 10'd3);
    check("w3_addr", {22'h0, w_addr}, 32'd1);
    check("w3_addr_out", {22'h0, w_addr_out}, 32'd1);
    check("w3_valid", {31'h0, w_valid}, 32'h1);
    step(); #1;
    check_buf("s4", 1'b1, 32'hA000_0003, 10'd4); check_req("s4", 1'b1, 10'd4);

    // Stall for 3 cycles while holding instruction 4.
    step(); stall = 1'b1; #1;
    check_buf("st0", 1'b1, 32'hA000_0004, 10'd5); check_req("st0", 1'b0, 10'd5);
    step(); #1;
    check_buf("st1", 1'b1, 32'hA000_0004, 10'd5); check_req("st1", 1'b0, 10'd5);
    step(); #1;
    check_buf("st2", 1'b1, 32'hA000_0004, 10'd5); check_req("st2", 1'b0, 10'd5);
    step(); stall = 1'b0; #1;
    check_buf("st3", 1'b1, 32'hA000_0004, 10'd5); check_req("st3", 1'b1, 10'd5);
    step(); #1;
    check_buf("st4", 1'b1, 32'hA000_0005, 10'd6); check_req("st4", 1'b1, 10'd6);

    // Wait states: ready low for 2 cycles at address 6.
    imem_ready = 1'b0; #1;
    check_req("ws0", 1'b1, 10'd6);
    step(); #1;
    check_buf("ws1", 1'b0, 32'h0, 10'd0); check_req("ws1", 1'b1, 10'd6);
    step(); imem_ready = 1'b1; #1;
    check_buf("ws2", 1'b0, 32'h0, 10'd0); check_req("ws2", 1'b1, 10'd6);
    step(); #1;
    check_buf("ws3", 1'b1, 32'hA000_0006, 10'd7); check_req("ws3", 1'b1, 10'd7);

    // Branch in RUN while the buffer holds addr_out 7.
    branch_taken = 1'b1; branch_target = 10'h100; #1;
    check("br0_req", {31'h0, imem_req}, 32'h0);
    step(); branch_taken = 1'b0; #1;
    check_buf("br1", 1'b0, 32'h0, 10'd0); check_req("br1", 1'b1, 10'h100);
    step(); #1;
    check_buf("br2", 1'b1, 32'hA000_0100, 10'h101); check_req("br2", 1'b1, 10'h101);

    // Branch in WAIT: stale 0xDEADBEEF must be discarded after the drain.
    imem_ready = 1'b0;
    step(); branch_taken = 1'b1; branch_target = 10'h200; #1;
    check_buf("bw0", 1'b0, 32'h0, 10'd0); check_req("bw0", 1'b1, 10'h101);
    step(); branch_taken = 1'b0; #1;
    check_buf("bw1", 1'b0, 32'h0, 10'd0); check_req("bw1", 1'b1, 10'h101);
    step(); imem_ready = 1'b1; bad_data = 1'b1; #1;
    check_buf("bw2", 1'b0, 32'h0, 10'd0); check_req("bw2", 1'b1, 10'h101);
    step(); bad_data = 1'b0; #1;
    check_buf("bw3", 1'b0, 32'h0, 10'd0); check_req("bw3", 1'b1, 10'h200);
    step(); #1;
    check_buf("bw4", 1'b1, 32'hA000_0200, 10'h201);

    // Branch coinciding with ready in WAIT: data dropped, redirect immediate.
    imem_ready = 1'b0;
    step(); imem_ready = 1'b1; branch_taken = 1'b1; branch_target = 10'h050; #1;
    check_req("bwr0", 1'b1, 10'h201);
    step(); branch_taken = 1'b0; #1;
    check_buf("bwr1", 1'b0, 32'h0, 10'd0); check_req("bwr1", 1'b1, 10'h050);
    step(); #1;
    check_buf("bwr2", 1'b1, 32'hA000_0050, 10'h051);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
